// File: rtl/gorev_sirasi_denetleyici_pkg.sv
// Shared constants for the task scheduler: state encoding, stream widths and task codes.
package gorev_sirasi_denetleyici_pkg;

  localparam int GRV_GENISLIK   = 3;
  localparam int PIXEL_GENISLIK = 8;

  typedef enum logic [2:0] {
    BOS    = 3'd0,
    YUKLE  = 3'd1,
    BASLA  = 3'd2,
    AKIS   = 3'd3,
    BOSALT = 3'd4,
    BITTI  = 3'd5,
    ABORT  = 3'd6
  } durum_t;

  // Task codes understood by gorev_birimi
  localparam logic [GRV_GENISLIK-1:0] GRV0_D = 3'd0;
  localparam logic [GRV_GENISLIK-1:0] GRV1_T = 3'd1;
  localparam logic [GRV_GENISLIK-1:0] GRV2_E = 3'd2;
  localparam logic [GRV_GENISLIK-1:0] GRV3_M = 3'd3;
  localparam logic [GRV_GENISLIK-1:0] GRV4_H = 3'd4;
  localparam logic [GRV_GENISLIK-1:0] GRV5_V = 3'd5;
  localparam logic [GRV_GENISLIK-1:0] GRV6_O = 3'd6;
  localparam logic [GRV_GENISLIK-1:0] GRV7_X = 3'd7;

endpackage

// File: rtl/gorev_sirasi_denetleyici_kuyrugu.sv
// Small synchronous FIFO for task descriptors; the head entry is visible without a read latency
// so the scheduler can latch it in the same cycle it pops.
module gorev_kuyrugu #(
  parameter int GENISLIK = 43,
  parameter int DERINLIK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                yaz,
  input  logic [GENISLIK-1:0] yaz_veri,
  input  logic                oku,
  output logic [GENISLIK-1:0] bas_veri,
  output logic                dolu,
  output logic                bos
);

  localparam int ADR = $clog2(DERINLIK);

  logic [GENISLIK-1:0] bellek [DERINLIK];
  logic [ADR-1:0]      yaz_adr;
  logic [ADR-1:0]      oku_adr;
  logic [ADR:0]        sayi;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_adr <= '0;
      oku_adr <= '0;
      sayi    <= '0;
    end else begin
      if (yaz) yaz_adr <= yaz_adr + 1'b1;
      if (oku) oku_adr <= oku_adr + 1'b1;
      case ({yaz, oku})
        2'b10:   sayi <= sayi + 1'b1;
        2'b01:   sayi <= sayi - 1'b1;
        default: sayi <= sayi;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (yaz) bellek[yaz_adr] <= yaz_veri;
  end

  assign bas_veri = bellek[oku_adr];
  assign dolu     = (sayi == (ADR+1)'(DERINLIK));
  assign bos      = (sayi == '0);

endmodule

// File: rtl/gorev_sirasi_denetleyici.sv
// Task scheduler in front of gorev_birimi: queues descriptors, starts each task, feeds the
// requested input pixels, counts the expected output beats and aborts a task that goes silent.
module gorev_sirasi_denetleyici
  import gorev_sirasi_denetleyici_pkg::*;
#(
  parameter int GRV_BIT         = GRV_GENISLIK,
  parameter int PIXEL_BIT       = PIXEL_GENISLIK,
  parameter int SAYAC_BIT       = 20,
  parameter int KUYRUK_DERINLIK = 4,
  parameter int ZAMAN_ASIMI     = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 gorev_gecerli_i,
  input  logic [GRV_BIT-1:0]   gorev_i,
  input  logic [SAYAC_BIT-1:0] giris_sayi_i,
  input  logic [SAYAC_BIT-1:0] cikis_sayi_i,
  output logic                 gorev_hazir_o,
  input  logic                 pixel_gecerli_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  output logic                 pixel_hazir_o,
  output logic                 basla_o,
  output logic [GRV_BIT-1:0]   gorev_o,
  output logic                 etkin_o,
  output logic [PIXEL_BIT-1:0] pixel_o,
  output logic                 stal_o,
  input  logic                 birim_etkin_i,
  input  logic [PIXEL_BIT-1:0] birim_pixel_i,
  input  logic                 birim_stal_i,
  output logic                 cikis_gecerli_o,
  output logic [PIXEL_BIT-1:0] cikis_pixel_o,
  input  logic                 cikis_stal_i,
  output logic                 mesgul_o,
  output logic                 bitti_o,
  output logic                 hata_o,
  output logic                 fazla_o
);

  localparam int KAYIT_BIT = GRV_BIT + 2*SAYAC_BIT;
  localparam int BEKCI_BIT = $clog2(ZAMAN_ASIMI);
  // ABORT is entered exactly ZAMAN_ASIMI unstalled cycles after the last counted beat.
  localparam logic [BEKCI_BIT-1:0] BEKCI_ESIK = BEKCI_BIT'(ZAMAN_ASIMI - 2);

  durum_t               durum;
  logic [GRV_BIT-1:0]   aktif_gorev;
  logic [SAYAC_BIT-1:0] kalan_giris;
  logic [SAYAC_BIT-1:0] kalan_cikis;
  logic [SAYAC_BIT-1:0] kalan_cikis_sonraki;
  logic [BEKCI_BIT-1:0] bekci;
  logic                 fazla;

  logic                 kuyruk_dolu;
  logic                 kuyruk_bos;
  logic                 push;
  logic                 pop;
  logic [KAYIT_BIT-1:0] bas_kayit;
  logic [GRV_BIT-1:0]   bas_gorev;
  logic [SAYAC_BIT-1:0] bas_giris;
  logic [SAYAC_BIT-1:0] bas_cikis;

  logic akis;
  logic pencere;
  logic kabul;
  logic son_kabul;
  logic sayilan;

  assign push = gorev_gecerli_i && gorev_hazir_o;
  assign pop  = (durum == YUKLE);

  gorev_kuyrugu #(
    .GENISLIK (KAYIT_BIT),
    .DERINLIK (KUYRUK_DERINLIK)
  ) u_kuyruk (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .yaz      (push),
    .yaz_veri ({gorev_i, giris_sayi_i, cikis_sayi_i}),
    .oku      (pop),
    .bas_veri (bas_kayit),
    .dolu     (kuyruk_dolu),
    .bos      (kuyruk_bos)
  );

  assign {bas_gorev, bas_giris, bas_cikis} = bas_kayit;

  assign akis    = (durum == AKIS);
  assign pencere = akis || (durum == BOSALT);

  assign pixel_hazir_o = akis && (kalan_giris != '0) && !cikis_stal_i && !birim_stal_i;
  assign kabul         = pixel_hazir_o && pixel_gecerli_i;
  assign son_kabul     = kabul && (kalan_giris == SAYAC_BIT'(1));
  assign etkin_o       = kabul;
  assign pixel_o       = akis ? pixel_i : '0;
  assign stal_o        = cikis_stal_i;

  // Beats outside the count window never reach downstream.
  assign cikis_gecerli_o     = pencere && birim_etkin_i && (kalan_cikis != '0);
  assign cikis_pixel_o       = pencere ? birim_pixel_i : '0;
  assign sayilan             = cikis_gecerli_o && !cikis_stal_i;
  assign kalan_cikis_sonraki = sayilan ? kalan_cikis - 1'b1 : kalan_cikis;

  assign basla_o       = (durum == BASLA);
  assign gorev_o       = (durum == BOS) ? '0 : aktif_gorev;
  assign bitti_o       = (durum == BITTI);
  assign hata_o        = (durum == ABORT);
  assign mesgul_o      = (durum != BOS) || !kuyruk_bos;
  assign gorev_hazir_o = !kuyruk_dolu && !rst_i;
  assign fazla_o       = fazla;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum       <= BOS;
      aktif_gorev <= '0;
      kalan_giris <= '0;
      kalan_cikis <= '0;
      bekci       <= '0;
      fazla       <= 1'b0;
    end else begin
      kalan_cikis <= kalan_cikis_sonraki;
      bekci       <= '0;
      if (kabul) kalan_giris <= kalan_giris - 1'b1;
      if (birim_etkin_i && !cikis_gecerli_o) fazla <= 1'b1;

      case (durum)
        BOS: if (!kuyruk_bos) durum <= YUKLE;
        YUKLE: begin
          aktif_gorev <= bas_gorev;
          kalan_giris <= bas_giris;
          kalan_cikis <= bas_cikis;
          durum       <= BASLA;
        end
        // The unit ignores basla while stalled, so hold it until the stall clears.
        BASLA: if (!cikis_stal_i) durum <= (kalan_giris == '0) ? BOSALT : AKIS;
        AKIS: if (son_kabul) durum <= (kalan_cikis_sonraki == '0) ? BITTI : BOSALT;
        BOSALT: begin
          if (kalan_cikis_sonraki == '0) begin
            durum <= BITTI;
          end else if (sayilan) begin
            bekci <= '0;
          end else if (cikis_stal_i) begin
            bekci <= bekci;
          end else begin
            bekci <= bekci + 1'b1;
            if (bekci == BEKCI_ESIK) durum <= ABORT;
          end
        end
        BITTI, ABORT: durum <= kuyruk_bos ? BOS : YUKLE;
        default: durum <= BOS;
      endcase
    end
  end

endmodule

// File: tb/tb_gorev_sirasi_denetleyici.sv
// Directed bench for the task scheduler: single task, queue backpressure, stalls,
// unit readout stall, watchdog abort and reset mid-task.
module tb_gorev_sirasi_denetleyici;
  import gorev_sirasi_denetleyici_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        gorev_gecerli_i;
  logic [2:0]  gorev_i;
  logic [19:0] giris_sayi_i;
  logic [19:0] cikis_sayi_i;
  logic        gorev_hazir_o;
  logic        pixel_gecerli_i;
  logic [7:0]  pixel_i;
  logic        pixel_hazir_o;
  logic        basla_o;
  logic [2:0]  gorev_o;
  logic        etkin_o;
  logic [7:0]  pixel_o;
  logic        stal_o;
  logic        birim_etkin_i;
  logic [7:0]  birim_pixel_i;
  logic        birim_stal_i;
  logic        cikis_gecerli_o;
  logic [7:0]  cikis_pixel_o;
  logic        cikis_stal_i;
  logic        mesgul_o;
  logic        bitti_o;
  logic        hata_o;
  logic        fazla_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  gorev_sirasi_denetleyici #(
    .GRV_BIT         (3),
    .PIXEL_BIT       (8),
    .SAYAC_BIT       (20),
    .KUYRUK_DERINLIK (4),
    .ZAMAN_ASIMI     (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .gorev_gecerli_i (gorev_gecerli_i),
    .gorev_i         (gorev_i),
    .giris_sayi_i    (giris_sayi_i),
    .cikis_sayi_i    (cikis_sayi_i),
    .gorev_hazir_o   (gorev_hazir_o),
    .pixel_gecerli_i (pixel_gecerli_i),
    .pixel_i         (pixel_i),
    .pixel_hazir_o   (pixel_hazir_o),
    .basla_o         (basla_o),
    .gorev_o         (gorev_o),
    .etkin_o         (etkin_o),
    .pixel_o         (pixel_o),
    .stal_o          (stal_o),
    .birim_etkin_i   (birim_etkin_i),
    .birim_pixel_i   (birim_pixel_i),
    .birim_stal_i    (birim_stal_i),
    .cikis_gecerli_o (cikis_gecerli_o),
    .cikis_pixel_o   (cikis_pixel_o),
    .cikis_stal_i    (cikis_stal_i),
    .mesgul_o        (mesgul_o),
    .bitti_o         (bitti_o),
    .hata_o          (hata_o),
    .fazla_o         (fazla_o)
  );

  // Inputs are driven at posedge+1, outputs sampled at posedge+2.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic push(input logic [2:0] g, input logic [19:0] gi, input logic [19:0] co);
    gorev_gecerli_i = 1'b1;
    gorev_i         = g;
    giris_sayi_i    = gi;
    cikis_sayi_i    = co;
    tick();
    gorev_gecerli_i = 1'b0;
  endtask

  int basla_n, bgorev, hs, pixbad, hz_bad, bitti_n, sira, d5_i;
  int stl_basla, stl_bad, bs_bad, sent, early, hata_at, wd_bitti, sonraki_bitti, rst_bad;

  initial begin
    rst_i = 1'b1; gorev_gecerli_i = 1'b0; gorev_i = '0; giris_sayi_i = '0; cikis_sayi_i = '0;
    pixel_gecerli_i = 1'b1; pixel_i = 8'h5A; birim_etkin_i = 1'b0; birim_pixel_i = 8'h00;
    birim_stal_i = 1'b0; cikis_stal_i = 1'b0;

    // Reset state
    repeat (2) tick();
    settle();
    check("rst_bayraklar", {basla_o, etkin_o, pixel_hazir_o, cikis_gecerli_o, bitti_o,
                            hata_o, fazla_o, mesgul_o, gorev_hazir_o, stal_o}, 0);
    check("rst_veri", {pixel_o, cikis_pixel_o, gorev_o}, 0);
    rst_i = 1'b0;
    tick(); settle();
    check("rst_sonrasi_hazir", gorev_hazir_o, 1);

    // GRV3_M, 9 inputs, 1 output beat 3 cycles after the last input
    push(GRV3_M, 20'd9, 20'd1);
    basla_n = 0; bgorev = 0; hs = 0; pixbad = 0;
    for (int i = 0; i < 40 && hs < 9; i++) begin
      pixel_i = 8'(i * 7 + 1);
      settle();
      if (basla_o) begin basla_n++; bgorev = int'(gorev_o); end
      if (pixel_hazir_o && pixel_gecerli_i) begin
        hs++;
        if (etkin_o !== 1'b1 || pixel_o !== pixel_i) pixbad++;
      end else if (etkin_o) pixbad++;
      tick();
    end
    check("t1_basla_sayisi", basla_n, 1);
    check("t1_basla_gorev", bgorev, GRV3_M);
    check("t1_el_sikisma", hs, 9);
    check("t1_pixel_yolu", pixbad, 0);
    settle();
    check("t1_giris_bitti", pixel_hazir_o, 0);
    tick(); tick();
    birim_etkin_i = 1'b1; birim_pixel_i = 8'hA5;
    settle();
    check("t1_cikis_gecerli", cikis_gecerli_o, 1);
    check("t1_cikis_pixel", cikis_pixel_o, 8'hA5);
    check("t1_bitti_erken", bitti_o, 0);
    tick();
    birim_etkin_i = 1'b0;
    settle();
    check("t1_bitti", bitti_o, 1);
    tick(); settle();
    check("t1_sonrasi", {bitti_o, mesgul_o, fazla_o}, 0);

    // Queue: hold T0 in BOSALT, fill 4 slots, the 5th waits for the next pop
    push(GRV0_D, 20'd0, 20'd1);
    repeat (4) tick();
    hz_bad = 0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      if (!gorev_hazir_o) hz_bad++;
      push(3'(k), 20'd0, 20'd0);
    end
    check("t2_hazir_dolmadan", hz_bad, 0);
    gorev_gecerli_i = 1'b1; gorev_i = 3'd5; giris_sayi_i = '0; cikis_sayi_i = '0;
    settle();
    check("t2_dolu_hazir", gorev_hazir_o, 0);
    birim_etkin_i = 1'b1; birim_pixel_i = 8'h3C;
    tick();
    birim_etkin_i = 1'b0;
    settle();
    check("t2_t0_bitti", bitti_o, 1);
    bitti_n = 0; sira = 0; d5_i = -1;
    for (int i = 0; i < 60 && bitti_n < 5; i++) begin
      tick();
      if (d5_i >= 0) gorev_gecerli_i = 1'b0;
      settle();
      if (basla_o) sira = (sira << 3) | int'(gorev_o);
      if (bitti_o) bitti_n++;
      if (gorev_gecerli_i && gorev_hazir_o && d5_i < 0) d5_i = i;
    end
    gorev_gecerli_i = 1'b0;
    check("t2_besinci_kabul", d5_i, 1);
    check("t2_bitti_sayisi", bitti_n, 5);
    check("t2_sira", sira, 32'o12345);
    tick(); settle();
    check("t2_bos", {mesgul_o, fazla_o}, 0);

    // Downstream stall during BASLA and mid-AKIS
    push(GRV2_E, 20'd4, 20'd2);
    tick(); tick();
    cikis_stal_i = 1'b1; stl_basla = 0; stl_bad = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (basla_o) stl_basla++;
      if (pixel_hazir_o || etkin_o) stl_bad++;
      tick();
    end
    cikis_stal_i = 1'b0;
    settle();
    check("t3_basla_tutuldu", stl_basla, 3);
    check("t3_basla_stal_sonrasi", basla_o, 1);
    tick();
    hs = 0;
    for (int i = 0; i < 20 && hs < 4; i++) begin
      cikis_stal_i = (i >= 2 && i <= 4);
      settle();
      if (cikis_stal_i && (pixel_hazir_o || etkin_o)) stl_bad++;
      if (pixel_hazir_o && pixel_gecerli_i) hs++;
      tick();
    end
    cikis_stal_i = 1'b0;
    check("t3_stal_kabul_yok", stl_bad, 0);
    check("t3_el_sikisma", hs, 4);
    birim_etkin_i = 1'b1; birim_pixel_i = 8'h11; cikis_stal_i = 1'b1;
    settle();
    check("t3_stal_cikis_tutuldu", cikis_gecerli_o, 1);
    tick();
    cikis_stal_i = 1'b0;
    tick();
    settle();
    check("t3_bitti_erken", bitti_o, 0);
    tick();
    birim_etkin_i = 1'b0;
    settle();
    check("t3_bitti", bitti_o, 1);
    check("t3_fazla", fazla_o, 0);

    // GRV4_H with unit readout stall pattern 1,1,0 and 768 output beats
    tick();
    push(GRV4_H, 20'd6, 20'd768);
    tick(); tick();
    hs = 0; bs_bad = 0;
    for (int i = 0; i < 40 && hs < 6; i++) begin
      birim_stal_i = ((i % 3) != 2);
      settle();
      if (birim_stal_i && (pixel_hazir_o || etkin_o)) bs_bad++;
      if (pixel_hazir_o && pixel_gecerli_i) hs++;
      tick();
    end
    birim_stal_i = 1'b0;
    check("t4_birim_stal", bs_bad, 0);
    check("t4_el_sikisma", hs, 6);
    sent = 0; early = 0;
    for (int i = 0; i < 1200 && sent < 768; i++) begin
      birim_etkin_i = ((i % 4) != 3);
      birim_pixel_i = 8'(i);
      settle();
      if (bitti_o || hata_o) early++;
      if (birim_etkin_i) sent++;
      tick();
    end
    birim_etkin_i = 1'b0;
    settle();
    check("t4_erken_bitti", early, 0);
    check("t4_bitti_768", bitti_o, 1);

    // Watchdog: 5 of 10 beats, stall freezes it for 2 cycles, then abort
    tick();
    push(GRV5_V, 20'd0, 20'd10);
    push(GRV6_O, 20'd0, 20'd0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      birim_etkin_i = 1'b1;
      tick();
    end
    birim_etkin_i = 1'b0;
    hata_at = 0; wd_bitti = 0;
    for (int n = 1; n <= 40 && hata_at == 0; n++) begin
      cikis_stal_i = (n == 5 || n == 6);
      settle();
      if (bitti_o) wd_bitti++;
      if (hata_o) hata_at = n;
      tick();
    end
    cikis_stal_i = 1'b0;
    check("t5_hata_gecikme", hata_at, 18);
    check("t5_bitti_yok", wd_bitti, 0);
    birim_etkin_i = 1'b1;
    settle();
    check("t5_hata_tek_darbe", hata_o, 0);
    check("t5_gec_vurus_dusuruldu", {cikis_gecerli_o, fazla_o}, 0);
    tick();
    birim_etkin_i = 1'b0;
    settle();
    check("t5_fazla", fazla_o, 1);
    sonraki_bitti = 0;
    for (int i = 0; i < 10 && sonraki_bitti == 0; i++) begin
      tick(); settle();
      if (bitti_o) sonraki_bitti = i + 1;
    end
    check("t5_sonraki_gorev", sonraki_bitti, 2);

    // Reset mid-AKIS with two tasks queued
    tick();
    push(GRV1_T, 20'd5, 20'd1);
    push(GRV2_E, 20'd3, 20'd1);
    push(GRV3_M, 20'd3, 20'd1);
    tick();
    settle();
    check("t6_akista", pixel_hazir_o, 1);
    rst_i = 1'b1;
    tick(); settle();
    check("t6_rst_bayraklar", {basla_o, etkin_o, pixel_hazir_o, cikis_gecerli_o, bitti_o,
                               hata_o, fazla_o, mesgul_o, gorev_hazir_o, stal_o}, 0);
    check("t6_rst_veri", {pixel_o, cikis_pixel_o, gorev_o}, 0);
    rst_i = 1'b0;
    rst_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      if (bitti_o || hata_o || mesgul_o || etkin_o || basla_o) rst_bad++;
    end
    check("t6_rst_sonrasi_sessiz", rst_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
